collatz_iter: RTL

COLLATZ_ITER -- requirements
Module: collatz_iter

---
 rtl/collatz_pkg.sv | 17 +
 rtl/collatz_step.sv | 35 +++
 rtl/collatz_iter.sv | 96 +++++++++
 3 files changed

// File: rtl/collatz_pkg.sv
// Shared types and defaults for the Collatz step-counting iterator.
`timescale 1ns/1ps
package collatz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_CWIDTH = 16;

  // Count value reported when the step counter would wrap.
  localparam logic [DEF_CWIDTH-1:0] COUNT_SAT = '1;

endpackage

// File: rtl/collatz_step.sv
// One Collatz step: next n, count increment and 3n+1 overflow flag.
// COLLATZ_SHORTCUT_EN folds the halving after 3n+1 into the same step.
`timescale 1ns/1ps
module collatz_step
  import collatz_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] n_next,
  output logic [1:0]       inc,
  output logic             ovf
);

  logic [WIDTH+1:0] triple;

  always_comb begin
    triple = {2'b00, n} + {1'b0, n, 1'b0} + (WIDTH+2)'(1);
    n_next = n >> 1;
    inc    = 2'd1;
    ovf    = 1'b0;
    if (n[0]) begin
      // Overflow is judged on the unshifted 3n+1 so both builds abort identically.
      ovf = |triple[WIDTH+1:WIDTH];
`ifdef COLLATZ_SHORTCUT_EN
      n_next = triple[WIDTH:1];
      inc    = 2'd2;
`else
      n_next = triple[WIDTH-1:0];
      inc    = 2'd1;
`endif
    end
  end

endmodule

// File: rtl/collatz_iter.sv
// Iterates the Collatz map from a seed and reports the step count to reach 1.
// Optional macro COLLATZ_SHORTCUT_EN (in collatz_step) halves odd-step latency.
`timescale 1ns/1ps
module collatz_iter
  import collatz_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned CWIDTH = DEF_CWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [WIDTH-1:0]  start,
  output logic              busy,
  output logic              done,
  output logic [CWIDTH-1:0] count,
  output logic              err
);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  n_q, n_d;
  logic [CWIDTH-1:0] count_q, count_d;
  logic              err_q, err_d;

  logic [WIDTH-1:0]  step_n;
  logic [1:0]        step_inc;
  logic              step_ovf;
  logic [CWIDTH:0]   count_sum;

  collatz_step #(.WIDTH(WIDTH)) u_step (
    .n      (n_q),
    .n_next (step_n),
    .inc    (step_inc),
    .ovf    (step_ovf)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    count_d   = count_q;
    err_d     = err_q;
    count_sum = {1'b0, count_q} + (CWIDTH+1)'(step_inc);
    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          state_d = RUN;
          n_d     = start;
          count_d = '0;
          err_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Overflow takes priority over counter wrap so count freezes at completed steps.
        if (n_q == WIDTH'(1)) begin
          state_d = DONE;
        end else if (n_q == '0) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (step_ovf) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (count_sum[CWIDTH]) begin
          state_d = DONE;
          err_d   = 1'b1;
          count_d = '1;
        end else begin
          n_d     = step_n;
          count_d = count_sum[CWIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign count = count_q;
  assign err   = err_q;

endmodule
